vga_sync: RTL and testbench

// - Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
// - Produces the pixel coordinates x/y that drive every sprite/ROM overlay stage (title, box, pipes, score).
// - Also drives the hsync/vsync pins, a video_on blanking qualifier, a pixel-rate enable and an end-of-frame strobe.
// - Sits directly upstream of all overlay blocks and the final rgb mux.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/pixel_tick_div.sv | 47 ++++
 rtl/vga_sync.sv | 128 ++++++++++++
 tb/tb_vga_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Screen geometry for 640x480@60 Hz VGA timing, shared by the sync generator
// and by every overlay stage that needs to know where the visible area ends.
// Contents:
//   - H_*/V_* porch, pulse and display widths, plus the line/frame totals
//   - sync-window bounds (inclusive) for hsync and vsync
//   - PIX_DIV: system clocks per pixel (100 MHz -> 25 MHz)
//   - coord_t: 10-bit pixel coordinate type
//   - in_window(): inclusive range test used for the sync windows
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W   = 10;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 800

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;  // 525

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;                 // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;           // 751
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;                 // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;           // 491

    localparam int PIX_DIV   = 4;

    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive window test; only >= / <= compares, no wrap arithmetic.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// ---------------------------------------------------------------------------
// pixel_tick_div
// Divides the system clock down to a one-clock pixel strobe. A small counter
// runs 0..PIX_DIV-1 continuously; p_tick is registered and is high for
// exactly one clock in every PIX_DIV. The first p_tick appears PIX_DIV clocks
// after reset release.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   tick_next  out  high in the clock before p_tick (p_tick's next value);
//                   lets a consumer register a flag coincident with p_tick
//   p_tick     out  registered one-clock pixel strobe
// ---------------------------------------------------------------------------
module pixel_tick_div #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick_next,
    output logic p_tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;

    always_comb begin
        tick_next = (div_q == DIV_LAST);
        div_d     = tick_next ? '0 : div_q + DIV_W'(1);
        p_tick_d  = tick_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            p_tick_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            p_tick_q <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
// VGA timing generator: pixel strobe, x/y pixel coordinates, active-low
// hsync/vsync, the video_on blanking qualifier and an end-of-frame strobe.
// Geometry defaults to 640x480@60 Hz from vga_timing_pkg; the parameters
// exist so a reduced geometry can be built without editing the package.
// Ports:
//   clk        in   system clock (100 MHz)
//   reset_n    in   asynchronous active-low reset, synchronous release
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high while (x,y) lies in the visible area
//   p_tick     out  one-clock pixel strobe, one in every PIX_DIV clocks
//   frame_end  out  one-clock strobe coincident with the p_tick on which the
//                   last pixel (H_TOTAL-1, V_TOTAL-1) is presented
//   x, y       out  current pixel column / row
// Strobe semantics: p_tick is a pure qualifier with no back-pressure. x, y,
// hsync, vsync and video_on change only on the clock edge immediately after
// a p_tick and hold for PIX_DIV clocks, so a downstream synchronous ROM can
// use one clock of read latency inside a pixel.
// ---------------------------------------------------------------------------
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int P_H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int P_H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int P_H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int P_H_BACK    = vga_timing_pkg::H_BACK,
    parameter int P_V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int P_V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int P_V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int P_V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         p_tick,
    output logic         frame_end,
    output logic [9:0]   x,
    output logic [9:0]   y
);

    localparam int HT = P_H_DISPLAY + P_H_FRONT + P_H_SYNC + P_H_BACK;
    localparam int VT = P_V_DISPLAY + P_V_FRONT + P_V_SYNC + P_V_BACK;

    localparam coord_t H_LAST  = coord_t'(HT - 1);
    localparam coord_t V_LAST  = coord_t'(VT - 1);
    localparam coord_t H_VIS   = coord_t'(P_H_DISPLAY);
    localparam coord_t V_VIS   = coord_t'(P_V_DISPLAY);
    localparam coord_t HS_LO   = coord_t'(P_H_DISPLAY + P_H_FRONT);
    localparam coord_t HS_HI   = coord_t'(P_H_DISPLAY + P_H_FRONT + P_H_SYNC - 1);
    localparam coord_t VS_LO   = coord_t'(P_V_DISPLAY + P_V_FRONT);
    localparam coord_t VS_HI   = coord_t'(P_V_DISPLAY + P_V_FRONT + P_V_SYNC - 1);

    logic   tick_next;
    logic   p_tick_q;

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   video_on_q, video_on_d;
    logic   frame_end_q, frame_end_d;

    pixel_tick_div #(
        .PIX_DIV   (PIX_DIV)
    ) u_pixel_tick_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_next (tick_next),
        .p_tick    (p_tick_q)
    );

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        video_on_d  = video_on_q;

        if (p_tick_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
            // Decoded from the next coordinates so the registered sync and
            // blanking flags line up with x/y with no pipeline skew.
            hsync_d    = !in_window(x_d, HS_LO, HS_HI);
            vsync_d    = !in_window(y_d, VS_LO, VS_HI);
            video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
        end

        // x/y do not move on the edge that raises p_tick, so the current
        // coordinates are the ones presented during that p_tick.
        frame_end_d = tick_next && (x_q == H_LAST) && (y_q == V_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign p_tick    = p_tick_q;
    assign frame_end = frame_end_q;
    assign x         = x_q;
    assign y         = y_q;

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
// Two instances share clock and reset: dut_a at full 640x480 geometry and
// dut_b at a reduced 15x11 geometry so whole frames (frame_end, vsync, y
// wrap) are covered in a short run. Expected outputs come from a closed-form
// model: after n active edges since release, k=(n-1)/4 pixels have been
// advanced, x=k%H_TOTAL, y=(k/H_TOTAL)%V_TOTAL, and p_tick is high when n
// is a multiple of 4.
// ---------------------------------------------------------------------------
module tb_vga_sync;

    localparam int W = 50;

    logic       clk;
    logic       reset_n;

    logic       hsync_a, vsync_a, video_on_a, p_tick_a, frame_end_a;
    logic [9:0] x_a, y_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, frame_end_b;
    logic [9:0] x_b, y_b;

    vga_sync dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .hsync     (hsync_a),
        .vsync     (vsync_a),
        .video_on  (video_on_a),
        .p_tick    (p_tick_a),
        .frame_end (frame_end_a),
        .x         (x_a),
        .y         (y_a)
    );

    vga_sync #(
        .P_H_DISPLAY (8),
        .P_H_FRONT   (2),
        .P_H_SYNC    (3),
        .P_H_BACK    (2),
        .P_V_DISPLAY (6),
        .P_V_FRONT   (1),
        .P_V_SYNC    (2),
        .P_V_BACK    (2)
    ) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .hsync     (hsync_b),
        .vsync     (vsync_b),
        .video_on  (video_on_b),
        .p_tick    (p_tick_b),
        .frame_end (frame_end_b),
        .x         (x_b),
        .y         (y_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_fail;
    int           edges;
    int           tick_cnt;
    int           fe_cnt_b;

    // Closed-form reference: {hsync, vsync, video_on, p_tick, frame_end, x, y}
    function automatic logic [24:0] model(input int n,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
        int   ht;
        int   vt;
        int   k;
        int   px;
        int   py;
        logic pt, fe, hsy, vsy, vo;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        if (n == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        k   = (n - 1) / 4;
        px  = k % ht;
        py  = (k / ht) % vt;
        pt  = (n % 4 == 0);
        fe  = pt && (px == ht - 1) && (py == vt - 1);
        hsy = !((px >= hd + hf) && (px < hd + hf + hs));
        vsy = !((py >= vd + vf) && (py < vd + vf + vs));
        vo  = (k > 0) && (px < hd) && (py < vd);
        return {hsy, vsy, vo, pt, fe, 10'(px), 10'(py)};
    endfunction

    function automatic logic [24:0] model_a(input int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic logic [24:0] model_b(input int n);
        return model(n, 8, 2, 3, 2, 6, 1, 2, 2);
    endfunction

    function automatic logic [24:0] act_a();
        return {hsync_a, vsync_a, video_on_a, p_tick_a, frame_end_a, x_a, y_a};
    endfunction

    function automatic logic [24:0] act_b();
        return {hsync_b, vsync_b, video_on_b, p_tick_b, frame_end_b, x_b, y_b};
    endfunction

    task automatic check25(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got hs=%b vs=%b vo=%b pt=%b fe=%b x=%0d y=%0d, expected hs=%b vs=%b vo=%b pt=%b fe=%b x=%0d y=%0d",
                     name, $time, act[24], act[23], act[22], act[21], act[20], act[19:10], act[9:0],
                     exp[24], exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One entry per active edge; reset held low means the model is at n=0.
    task automatic run_cycles(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            if (reset_n) edges++;
            else         edges = 0;
            exp_q.push_back({model_a(edges), model_b(edges)});
            #1;
            if (p_tick_a)    tick_cnt++;
            if (frame_end_b) fe_cnt_b++;
        end
    endtask

    // Assert reset between edges, after the monitor has sampled the cycle,
    // and check that the outputs clear without any clock edge.
    task automatic assert_reset_mid();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check25("async_reset_a", act_a(), model_a(0));
        check25("async_reset_b", act_b(), model_b(0));
        edges = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check25("cycle_a", act_a(), e[49:25]);
            check25("cycle_b", act_b(), e[24:0]);
            n_vec++;
            if (video_on_a && (!hsync_a || !vsync_a)) begin
                n_fail++;
                $display("FAIL blank_a video_on=%b while hsync=%b vsync=%b, required video_on=0",
                         video_on_a, hsync_a, vsync_a);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        n_vec    = 0;
        n_fail   = 0;
        edges    = 0;
        tick_cnt = 0;
        fe_cnt_b = 0;
        reset_n  = 1'b1;

        #3;
        reset_n = 1'b0;
        #1;
        check25("reset_a", act_a(), model_a(0));
        check25("reset_b", act_b(), model_b(0));
        run_cycles(10);

        // Long run from release: covers first tick, line wrap of dut_a,
        // its full hsync window, and many whole frames of dut_b.
        release_reset();
        tick_cnt = 0;
        fe_cnt_b = 0;
        run_cycles(10000);
        check_int("p_tick_count_10000", tick_cnt, 2500);
        // dut_b frame is 15*11 pixels = 660 clocks; first frame_end at edge 660.
        check_int("frame_end_count_b", fe_cnt_b, 10000 / 660);

        // Random mid-operation resets at arbitrary points.
        for (int i = 0; i < 8; i++) begin
            run_cycles($urandom_range(40, 2500));
            assert_reset_mid();
            run_cycles($urandom_range(1, 6));
            release_reset();
        end
        run_cycles(1500);

        @(negedge clk);
        #1;
        check_int("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
